// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, FSM state type and opcode-class helpers shared by alu_mc,
// its mul/div iterator and the testbench.
package alu_pkg;

  localparam int ALU_OP_WIDTH = 5;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_state_t;

  function automatic logic is_muldiv(input logic [ALU_OP_WIDTH-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [ALU_OP_WIDTH-1:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_signed_a(input logic [ALU_OP_WIDTH-1:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input logic [ALU_OP_WIDTH-1:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle for alu_mc; master = requester/consumer,
// slave = the ALU.
interface alu_mc_if #(
  parameter int ALU_WIDTH = 32,
  parameter int TAG_WIDTH = 5
) ();
  import alu_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [ALU_OP_WIDTH-1:0] in_op;
  logic [ALU_WIDTH-1:0]    in_a;
  logic [ALU_WIDTH-1:0]    in_b;
  logic [TAG_WIDTH-1:0]    in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [ALU_WIDTH-1:0]    out_result;
  logic [TAG_WIDTH-1:0]    out_tag;
  logic                    out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared shift-add multiplier / restoring divider on operand magnitudes,
// one bit per cycle with sign fix-up on the last step. Built only when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int ALU_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [ALU_WIDTH-1:0]    a,
  input  logic [ALU_WIDTH-1:0]    b,
  output logic                    done,
  output logic [ALU_WIDTH-1:0]    result
);
  localparam int CNT_W = $clog2(ALU_WIDTH);

  logic [ALU_WIDTH-1:0]   hi, lo, opnd, hi_nxt, lo_nxt, a_mag, b_mag, sel;
  logic [ALU_WIDTH:0]     mul_sum, rem_shift, diff;
  logic [2*ALU_WIDTH-1:0] prod;
  logic [CNT_W-1:0]       cnt;
  logic                   busy, div_mode, sel_alt, neg, a_neg, b_neg, alt_op;

  assign a_neg  = is_signed_a(op) && a[ALU_WIDTH-1];
  assign b_neg  = is_signed_b(op) && b[ALU_WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign alt_op = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
  assign done   = busy && (cnt == CNT_W'(ALU_WIDTH - 1));

  // NOTE: every variable gets a value on every path, so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_shift = {hi, lo[ALU_WIDTH-1]};
    diff      = rem_shift - {1'b0, opnd};
    if (div_mode) begin
      // A borrow means the divisor did not fit: keep the shifted remainder, quotient bit 0.
      hi_nxt = diff[ALU_WIDTH] ? rem_shift[ALU_WIDTH-1:0] : diff[ALU_WIDTH-1:0];
      lo_nxt = {lo[ALU_WIDTH-2:0], ~diff[ALU_WIDTH]};
    end else begin
      hi_nxt = mul_sum[ALU_WIDTH:1];
      lo_nxt = {mul_sum[0], lo[ALU_WIDTH-1:1]};
    end
    prod = neg ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    sel  = sel_alt ? hi_nxt : lo_nxt;
    if (div_mode) result = neg ? -sel : sel;
    else          result = sel_alt ? prod[2*ALU_WIDTH-1:ALU_WIDTH] : prod[ALU_WIDTH-1:0];
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      sel_alt  <= 1'b0;
      neg      <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      hi       <= '0;
      div_mode <= is_div(op);
      sel_alt  <= alt_op;
      // Remainder follows the dividend's sign; quotient and product use sign(a) ^ sign(b).
      neg      <= a_neg ^ ((is_div(op) && alt_op) ? 1'b0 : b_neg);
      opnd     <= is_div(op) ? b_mag : a_mag;
      lo       <= is_div(op) ? a_mag : b_mag;
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= done ? '0 : cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/RV32M ALU behind a valid/ready handshake with tag pass-through.
// Define ALU_MULDIV_EN to build the iterative mul/div path; otherwise opcodes 10-17 are illegal.
module alu_mc
  import alu_pkg::*;
#(
  parameter int ALU_WIDTH = 32,
  parameter int TAG_WIDTH = 5
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(ALU_WIDTH);

  alu_state_t           state;
  logic                 accept, lt_s, lt_u, base_ill, go_busy;
  logic [SHW-1:0]       shamt;
  logic [ALU_WIDTH-1:0] base_res;

  assign bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign shamt        = bus.in_b[SHW-1:0];
  assign lt_s         = $signed(bus.in_a) < $signed(bus.in_b);
  assign lt_u         = bus.in_a < bus.in_b;

`ifdef ALU_MULDIV_EN
  localparam logic [ALU_WIDTH-1:0] MIN_VAL = {1'b1, {(ALU_WIDTH-1){1'b0}}};

  logic                 iter_done, rem_op;
  logic [ALU_WIDTH-1:0] iter_result;

  assign rem_op = (bus.in_op == OP_REM) || (bus.in_op == OP_REMU);

  alu_muldiv_iter #(.ALU_WIDTH(ALU_WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && go_busy),
    .op     (bus.in_op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .done   (iter_done),
    .result (iter_result)
  );
`endif

  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    go_busy  = 1'b0;
    case (bus.in_op)
      OP_ADD:  base_res = bus.in_a + bus.in_b;
      OP_SUB:  base_res = bus.in_a - bus.in_b;
      OP_AND:  base_res = bus.in_a & bus.in_b;
      OP_OR:   base_res = bus.in_a | bus.in_b;
      OP_XOR:  base_res = bus.in_a ^ bus.in_b;
      OP_SLL:  base_res = bus.in_a << shamt;
      OP_SRL:  base_res = bus.in_a >> shamt;
      OP_SRA:  base_res = $signed(bus.in_a) >>> shamt;
      OP_SLT:  base_res = {{(ALU_WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: base_res = {{(ALU_WIDTH-1){1'b0}}, lt_u};
      default: begin
`ifdef ALU_MULDIV_EN
        // Divide-by-zero and signed overflow have fixed answers, so they skip the iterator.
        if (!is_muldiv(bus.in_op))
          base_ill = 1'b1;
        else if (is_div(bus.in_op) && (bus.in_b == '0))
          base_res = rem_op ? bus.in_a : '1;
        else if (is_div(bus.in_op) && is_signed_a(bus.in_op) &&
                 (bus.in_a == MIN_VAL) && (bus.in_b == '1))
          base_res = rem_op ? '0 : bus.in_a;
        else
          go_busy = 1'b1;
`else
        base_ill = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_tag     <= {TAG_WIDTH{1'b0}};
      bus.out_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            bus.out_tag     <= bus.in_tag;
            bus.out_result  <= base_res;
            bus.out_illegal <= base_ill;
            bus.out_valid   <= !go_busy;
            state           <= go_busy ? ST_BUSY : ST_DONE;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
`ifdef ALU_MULDIV_EN
        ST_BUSY: begin
          if (iter_done) begin
            bus.out_result <= iter_result;
            bus.out_valid  <= 1'b1;
            state          <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc against a 64-bit arithmetic reference
// of the RISC-V integer/M-extension rules; follows ALU_MULDIV_EN like the design.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int TW = 5;
`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_mc_if #(.ALU_WIDTH(W), .TAG_WIDTH(TW)) bus ();

  alu_mc #(.ALU_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result, illegal flag and latency from the ISA rules using 64-bit integers.
  task automatic ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ill, output int lat);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    r   = '0;
    ill = 1'b0;
    lat = 1;
    if (op >= 5'd10 && op <= 5'd17 && !MULDIV) begin
      ill = 1'b1;
    end else begin
      case (op)
        OP_ADD:    r = a + b;
        OP_SUB:    r = a - b;
        OP_AND:    r = a & b;
        OP_OR:     r = a | b;
        OP_XOR:    r = a ^ b;
        OP_SLL:    r = 32'(ua << b[4:0]);
        OP_SRL:    r = 32'(ua >> b[4:0]);
        OP_SRA:    r = 32'(sa >>> b[4:0]);
        OP_SLT:    r = (sa < sb) ? 32'd1 : 32'd0;
        OP_SLTU:   r = (ua < ub) ? 32'd1 : 32'd0;
        OP_MUL:    begin p = sa * sb; r = p[31:0];  lat = W + 1; end
        OP_MULH:   begin p = sa * sb; r = p[63:32]; lat = W + 1; end
        OP_MULHSU: begin p = sa * ua; r = p[63:32]; lat = W + 1; end
        OP_MULHU:  begin p = ua * ub; r = p[63:32]; lat = W + 1; end
        OP_DIV: begin
          if (b == 0) r = 32'hFFFF_FFFF;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
          else begin r = 32'(sa / sb); lat = W + 1; end
        end
        OP_DIVU: begin
          if (b == 0) r = 32'hFFFF_FFFF;
          else begin r = 32'(ua / ub); lat = W + 1; end
        end
        OP_REM: begin
          if (b == 0) r = a;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
          else begin r = 32'(sa % sb); lat = W + 1; end
        end
        OP_REMU: begin
          if (b == 0) r = a;
          else begin r = 32'(ua % ub); lat = W + 1; end
        end
        default: ill = 1'b1;
      endcase
    end
  endtask

  // One request with out_ready held high; starts and ends with the DUT idle.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, output logic [W-1:0] r, output logic ill,
                        output logic [TW-1:0] t, output int lat, output bit rdy_busy);
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat      = 1;
    rdy_busy = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_busy = 1'b1;
      tick();
      lat++;
    end
    r   = bus.out_result;
    ill = bus.out_illegal;
    t   = bus.out_tag;
    tick();
  endtask

  task automatic exec_and_compare(input string name, input logic [4:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]  r, er;
    logic          ill, eill;
    logic [TW-1:0] t, tag;
    int            lat, elat;
    bit            rb;
    tag = TW'($urandom);
    ref_alu(op, a, b, er, eill, elat);
    run_op(op, a, b, tag, r, ill, t, lat, rb);
    checks++;
    if (r !== er || ill !== eill) begin
      failures++;
      $display("FAIL %s result: got %h ill=%b, expected %h ill=%b (op=%0d a=%h b=%h)",
               name, r, ill, er, eill, op, a, b);
    end
    checks++;
    if (t !== tag) begin
      failures++;
      $display("FAIL %s tag: got %0d, expected %0d", name, t, tag);
    end
    checks++;
    if (lat !== elat) begin
      failures++;
      $display("FAIL %s latency: got %0d, expected %0d (op=%0d)", name, lat, elat, op);
    end
    checks++;
    if (rb) begin
      failures++;
      $display("FAIL %s in_ready: high while iterating, expected low", name);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== '0 || bus.out_tag !== '0 ||
        bus.out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: got valid=%b result=%h tag=%0d ill=%b, expected all zero",
               bus.out_valid, bus.out_result, bus.out_tag, bus.out_illegal);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready: got %b, expected 1", bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_base_directed();
    exec_and_compare("add_7_5", OP_ADD, 32'd7, 32'd5);
    exec_and_compare("slt_m1_1", OP_SLT, 32'hFFFF_FFFF, 32'd1);
    exec_and_compare("sltu_m1_1", OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    exec_and_compare("sra_neg", OP_SRA, 32'h8000_00F0, 32'h0000_0124);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      bus.in_op    = OP_ADD;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_tag   = TW'(i);
      bus.in_valid = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b in_ready[%0d]: got %b, expected 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== a + b || bus.out_tag !== TW'(i)) begin
        failures++;
        $display("FAIL b2b result[%0d]: got valid=%b %h tag=%0d, expected valid=1 %h tag=%0d",
                 i, bus.out_valid, bus.out_result, bus.out_tag, a + b, i);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b drain: out_valid got %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_muldiv_directed();
    exec_and_compare("mulh_min_min", OP_MULH, 32'h8000_0000, 32'h8000_0000);
    exec_and_compare("mul_m1_3", OP_MUL, 32'hFFFF_FFFF, 32'd3);
    exec_and_compare("mulhsu_m1_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exec_and_compare("mulhu_m1_m1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exec_and_compare("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    exec_and_compare("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    exec_and_compare("divu_7_0", OP_DIVU, 32'd7, 32'd0);
    exec_and_compare("rem_7_0", OP_REM, 32'd7, 32'd0);
    exec_and_compare("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    exec_and_compare("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    a = $urandom;
    b = $urandom;
    bus.in_op     = OP_SUB;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = 5'd19;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    // A second request waits on the bus and must not be taken while the result is held.
    bus.in_op  = OP_ADD;
    bus.in_a   = ~a;
    bus.in_tag = 5'd3;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== a - b || bus.out_tag !== 5'd19 ||
          bus.out_illegal !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: got valid=%b %h tag=%0d ill=%b, expected valid=1 %h tag=19 ill=0",
                 k, bus.out_valid, bus.out_result, bus.out_tag, bus.out_illegal, a - b);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold in_ready[%0d]: got %b, expected 0", k, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== ~a + b || bus.out_tag !== 5'd3) begin
      failures++;
      $display("FAIL release accept: got valid=%b %h tag=%0d, expected valid=1 %h tag=3",
               bus.out_valid, bus.out_result, bus.out_tag, ~a + b);
    end
    bus.in_valid = 1'b0;
    tick();
    exec_and_compare("illegal_25", 5'd25, $urandom, $urandom);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    bus.in_op     = OP_DIVU;
    bus.in_a      = $urandom | 32'h1000;
    bus.in_b      = 32'd3;
    bus.in_tag    = 5'd21;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== '0 ||
        bus.out_tag !== '0) begin
      failures++;
      $display("FAIL mid reset: got valid=%b ready=%b result=%h tag=%0d, expected 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_result, bus.out_tag);
    end
    seen = 1'b0;
    repeat (40) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL mid reset discard: got a result after reset, expected none");
    end
    exec_and_compare("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    exec_and_compare("remu_100_7", OP_REMU, 32'd100, 32'd7);
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      exec_and_compare($sformatf("rand%0d", i), op, pick_operand(), pick_operand());
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_base_directed();
    test_back_to_back();
    test_muldiv_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised successor to the single-cycle integer ALU.
- Executes the RV32I base ops plus RV32M multiply/divide behind a valid/ready handshake.
- Base ops complete in one cycle; mul/div run iteratively over ALU_WIDTH cycles.
- Sits between operand fetch and writeback; an in-flight tag lets the control path match results to requests.

Parameters:
ALU_WIDTH, 32, operand/result width; power of two, >= 8
TAG_WIDTH, 5, width of opaque request tag (e.g. rd index), passed through unchanged

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  block can accept a request this cycle
in_op  in  5  alu_op_t opcode
in_a  in  ALU_WIDTH  operand 1
in_b  in  ALU_WIDTH  operand 2
in_tag  in  TAG_WIDTH  request tag
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_result  out  ALU_WIDTH  result
out_tag  out  TAG_WIDTH  tag of the request that produced out_result
out_illegal  out  1  opcode was unsupported; out_result = 0

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10, MULH=11, MULHSU=12, MULHU=13, DIV=14, DIVU=15, REM=16, REMU=17. Values 18-31 are illegal.
- Shift amount is in_b[$clog2(ALU_WIDTH)-1:0].
- SLT is a signed compare; SLTU is an unsigned compare. Both produce a zero-extended 0 or 1.
- FSM states:
  - IDLE: no request held.
  - BUSY: iterating a mul/div.
  - DONE: result held.
- Accept condition: in_valid && in_ready. On accept, opcode, operands and tag are registered.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is combinational from state and out_ready only, never from in_valid.
- Base ops and illegal ops: IDLE -> DONE; out_valid is asserted the cycle after accept (latency 1).
- MUL family:
  - Radix-2 shift-add on operand magnitudes, with sign fix-up at the end.
  - Sign handling: MULH treats a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - MUL returns the low half of the 2*ALU_WIDTH product; the MULH variants return the high half.
  - BUSY for exactly ALU_WIDTH cycles, then DONE; latency ALU_WIDTH+1.
- DIV family:
  - Restoring division on magnitudes, BUSY for ALU_WIDTH cycles; latency ALU_WIDTH+1.
  - Quotient sign = sign(a) xor sign(b). Remainder takes the sign of the dividend.
  - Divide by zero bypasses BUSY (latency 1): quotient = all ones, remainder = a.
  - Signed overflow (a = most negative, b = -1) bypasses BUSY (latency 1): quotient = a, remainder = 0.
- DONE, out_valid=1:
  - out_result, out_tag and out_illegal stay stable until out_ready.
  - out_ready && !in_valid -> IDLE.
  - out_ready && in_valid -> new request accepted in the same cycle (back-to-back base ops give throughput 1/cycle).
- No request is accepted while in BUSY.
- Reset (any state, including mid-iteration): state=IDLE, out_valid=0, out_result=0, out_tag=0, out_illegal=0, iteration counter=0. Any in-flight operation is discarded and no result is produced.

Optional Feature:
- ALU_MULDIV_EN defined: opcodes 10-17 are supported as described above.
- ALU_MULDIV_EN undefined:
  - Opcodes 10-17 are treated as illegal: latency 1, out_result=0, out_illegal=1.
  - The iterative datapath and BUSY state are not synthesised.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t (5-bit enum, values above).
  - ALU_OP_WIDTH=5.
  - is_muldiv(op), is_div(op) and is_signed_a/b(op) helper functions.
- Sub-module alu_muldiv_iter (under ALU_MULDIV_EN):
  - Holds the shared shift register and accumulator, plus the counter.
  - Interface: start / done / op / operand inputs.
  - The top level keeps the handshake FSM and the base-op logic.

Test Plan:
- Reset, then ADD a=7, b=5 with out_ready=1: out_valid on cycle 1, result 12, tag echoed. Follow with SLT a=0xFFFFFFFF, b=1: result 1. Follow with SLTU on the same operands: result 0.
- Back-to-back stream of 8 ADDs with in_valid and out_ready held at 1: one result per cycle, tags in order, in_ready never drops.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000 after 33 cycles. MUL a=0xFFFFFFFF (-1), b=3 -> 0xFFFFFFFD. in_ready must stay 0 throughout BUSY.
- DIV a=-7, b=2 -> -3; REM a=-7, b=2 -> -1; DIVU a=7, b=0 -> 0xFFFFFFFF with latency 1; DIV a=0x80000000, b=-1 -> 0x80000000, REM of the same -> 0.
- Backpressure: out_ready=0 for 5 cycles after a SUB result: out_result, out_tag and out_valid hold steady, in_ready=0. Illegal opcode 25 -> out_illegal=1, out_result=0.
- Assert rst mid-DIVU at iteration 10: next cycle out_valid=0 and state IDLE. Then DIVU a=100, b=7 -> 14, and REMU on the same operands -> 2.
